// File: rtl/sh7604_wdt.sv
// SH7604 watchdog timer: interval/watchdog counter with keyed register writes
// and a timed overflow pulse that drives WDTOVF_N and the internal reset request.
//
//   state | meaning
//   IDLE  | no overflow pulse in progress, WDTOVF_N high
//   PULSE | overflow pulse active, WDTOVF_N low, RST_REQ follows RSTE
module sh7604_wdt #(
    parameter int OVF_PULSE_LEN = 128
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    input  logic [1:0] A,
    input  logic [15:0] DI,
    input  logic       WE,
    input  logic       RE,
    output logic [7:0] DO,
    output logic       ITI,
    output logic       WDTOVF_N,
    output logic       RST_REQ,
    output logic       RST_TYPE
);

    localparam int PCW = (OVF_PULSE_LEN > 1) ? $clog2(OVF_PULSE_LEN) : 1;
    localparam logic [PCW-1:0] PULSE_LAST = PCW'(OVF_PULSE_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } pulse_state_t;

    // WTCSR / WTCNT / RSTCSR
    logic       ovf;
    logic       wtit;
    logic       tme;
    logic [2:0] cks;
    logic [7:0] wtcnt;
    logic       wovf;
    logic       rste;
    logic       rsts;

    logic [12:0] prescaler;
    logic [12:0] psc_mask;

    pulse_state_t     pulse_state, pulse_state_d;
    logic [PCW-1:0]   pulse_cnt, pulse_cnt_d;
    logic             rst_type_hold;

    logic       key_a5;
    logic       key_5a;
    logic       csr_cfg_wr;
    logic       cnt_wr;
    logic       wovf_clr;
    logic       rcsr_wr;
    logic       tick;
    logic       cnt_step;
    logic       cnt_ovf;
    logic       itv_ovf;
    logic       wdt_ovf;
    logic [7:0] rd_data;

    // Write decode: the upper byte is a key, anything unkeyed is dropped
    always_comb begin
        key_a5     = (DI[15:8] == 8'hA5);
        key_5a     = (DI[15:8] == 8'h5A);
        csr_cfg_wr = WE && (A == 2'd0) && key_a5;
        cnt_wr     = WE && (A == 2'd0) && key_5a;
        wovf_clr   = WE && (A == 2'd2) && key_a5 && (DI[7:0] == 8'h00);
        rcsr_wr    = WE && (A == 2'd2) && key_5a;
    end

    always_comb begin
        psc_mask = 13'h0001;
        case (cks)
            3'd0: psc_mask = 13'h0001;
            3'd1: psc_mask = 13'h003F;
            3'd2: psc_mask = 13'h007F;
            3'd3: psc_mask = 13'h00FF;
            3'd4: psc_mask = 13'h01FF;
            3'd5: psc_mask = 13'h03FF;
            3'd6: psc_mask = 13'h0FFF;
            3'd7: psc_mask = 13'h1FFF;
            default: psc_mask = 13'h0001;
        endcase
    end

    // A CPU load of WTCNT swallows a coincident tick, so it can never overflow
    always_comb begin
        tick     = CE && tme && ((prescaler & psc_mask) == psc_mask);
        cnt_step = tick && !cnt_wr;
        cnt_ovf  = cnt_step && (wtcnt == 8'hFF);
        itv_ovf  = cnt_ovf && !wtit;
        wdt_ovf  = cnt_ovf && wtit;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prescaler <= 13'd0;
        end else if (!tme) begin
            prescaler <= 13'd0;
        end else if (CE) begin
            prescaler <= prescaler + 13'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf   <= 1'b0;
            wtit  <= 1'b0;
            tme   <= 1'b0;
            cks   <= 3'd0;
            wtcnt <= 8'd0;
            wovf  <= 1'b0;
            rste  <= 1'b0;
            rsts  <= 1'b0;
        end else begin
            if (csr_cfg_wr) begin
                wtit <= DI[6];
                tme  <= DI[5];
                cks  <= DI[2:0];
            end

            if (itv_ovf) begin
                ovf <= 1'b1;
            end else if (csr_cfg_wr && !DI[7]) begin
                ovf <= 1'b0;
            end

            if (cnt_wr) begin
                wtcnt <= DI[7:0];
            end else if (cnt_step) begin
                wtcnt <= wtcnt + 8'd1;
            end

            if (wdt_ovf) begin
                wovf <= 1'b1;
            end else if (wovf_clr) begin
                wovf <= 1'b0;
            end

            if (rcsr_wr) begin
                rste <= DI[6];
                rsts <= DI[5];
            end
        end
    end

    // Pulse timer counts down from OVF_PULSE_LEN-1; a new overflow reloads it
    always_comb begin
        pulse_state_d = pulse_state;
        pulse_cnt_d   = pulse_cnt;
        if (wdt_ovf) begin
            pulse_state_d = PULSE;
            pulse_cnt_d   = PULSE_LAST;
        end else if ((pulse_state == PULSE) && CE) begin
            if (pulse_cnt == '0) begin
                pulse_state_d = IDLE;
            end else begin
                pulse_cnt_d = pulse_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pulse_state   <= IDLE;
            pulse_cnt     <= '0;
            rst_type_hold <= 1'b0;
        end else begin
            pulse_state <= pulse_state_d;
            pulse_cnt   <= pulse_cnt_d;
            if (wdt_ovf) begin
                rst_type_hold <= rsts;
            end
        end
    end

    always_comb begin
        rd_data = 8'hFF;
        case (A)
            2'd0: rd_data = {ovf, wtit, tme, 2'b11, cks};
            2'd1: rd_data = wtcnt;
            2'd2: rd_data = 8'hFF;
            2'd3: rd_data = {wovf, rste, rsts, 5'b11111};
            default: rd_data = 8'hFF;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            DO <= 8'h00;
        end else if (RE) begin
            DO <= rd_data;
        end
    end

    always_comb begin
        ITI      = ovf && !wtit;
        WDTOVF_N = (pulse_state != PULSE);
        RST_REQ  = (pulse_state == PULSE) && rste;
        RST_TYPE = (pulse_state == PULSE) ? rst_type_hold : rsts;
    end

endmodule
